uart_tx: RTL and testbench

//  Serial UART transmitter; the transmit-side counterpart of the team's UART_RX.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_counter.sv | 31 +++
 rtl/uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive sides: state encoding,
// legal frame-format ranges and bit-timing / parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Clock cycles per bit period, rounded down.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Even parity over an already-masked data word.
  function automatic logic even_parity(input logic [7:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, flagging the last
// cycle of each bit period with bit_done. clear holds the count at zero so the
// first period after release is full length.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_r;

  // Free-running bit-period counter, restarted on every bit boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clear || (count_r == LAST)) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  assign bit_done = (count_r == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, sent LSB-first as
// start + DATA_BITS data + optional even parity + STOP_BITS stop bits.
// Optional feature macro: UART_TX_PARITY_EN adds one even-parity bit after data.
// All outputs are registered; the line idles high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       serial
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [7:0] DATA_MASK = 8'(8'hFF >> (8 - DATA_BITS));
  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  generate
    if ((DATA_BITS < DATA_BITS_MIN) || (DATA_BITS > DATA_BITS_MAX)) begin : g_bad_data_bits
      $error("uart_tx: DATA_BITS must be in 5..8");
    end
    if ((STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX)) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be in 1..2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  uart_state_t state_r, state_nxt;
  logic [7:0]  shift_r, shift_nxt;
  logic [2:0]  bit_idx_r, bit_idx_nxt;
  logic        stop_cnt_r, stop_cnt_nxt;
  logic        serial_r, serial_nxt;
  logic        ready_r, ready_nxt;
  logic        busy_r, busy_nxt;
  logic        bit_done_s;
  logic        clear_s;
`ifdef UART_TX_PARITY_EN
  logic        parity_r, parity_nxt;
`endif

  // The bit timer only runs while a frame is on the line.
  assign clear_s = (state_r == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_s),
    .bit_done(bit_done_s)
  );

  // State, datapath and registered-output update; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      serial_r   <= 1'b1;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt;
      shift_r    <= shift_nxt;
      bit_idx_r  <= bit_idx_nxt;
      stop_cnt_r <= stop_cnt_nxt;
      serial_r   <= serial_nxt;
      ready_r    <= ready_nxt;
      busy_r     <= busy_nxt;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_nxt;
`endif
    end
  end

  // Next-state logic; outputs are computed for the next state so they stay registered.
  always_comb begin
    state_nxt    = state_r;
    shift_nxt    = shift_r;
    bit_idx_nxt  = bit_idx_r;
    stop_cnt_nxt = stop_cnt_r;
    serial_nxt   = serial_r;
    ready_nxt    = ready_r;
    busy_nxt     = busy_r;
`ifdef UART_TX_PARITY_EN
    parity_nxt   = parity_r;
`endif
    case (state_r)
      IDLE: begin
        serial_nxt = 1'b1;
        if (valid && ready_r) begin
          state_nxt    = START;
          shift_nxt    = data & DATA_MASK;
          bit_idx_nxt  = 3'd0;
          stop_cnt_nxt = 1'b0;
          serial_nxt   = 1'b0;
          ready_nxt    = 1'b0;
          busy_nxt     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_nxt   = even_parity(data & DATA_MASK);
`endif
        end else begin
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_nxt  = DATA;
          serial_nxt = shift_r[0];
          shift_nxt  = {1'b0, shift_r[7:1]};
        end else begin
          serial_nxt = 1'b0;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          if (bit_idx_r == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_nxt  = PARITY;
            serial_nxt = parity_r;
`else
            state_nxt  = STOP;
            serial_nxt = 1'b1;
`endif
          end else begin
            bit_idx_nxt = bit_idx_r + 3'd1;
            serial_nxt  = shift_r[0];
            shift_nxt   = {1'b0, shift_r[7:1]};
          end
        end else begin
          serial_nxt = serial_r;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done_s) begin
          state_nxt  = STOP;
          serial_nxt = 1'b1;
        end else begin
          serial_nxt = parity_r;
        end
      end
`endif
      STOP: begin
        serial_nxt = 1'b1;
        if (bit_done_s) begin
          if (stop_cnt_r == LAST_STOP) begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            stop_cnt_nxt = stop_cnt_r + 1'b1;
          end
        end else begin
          stop_cnt_nxt = stop_cnt_r;
        end
      end
      default: begin
        state_nxt  = IDLE;
        serial_nxt = 1'b1;
        ready_nxt  = 1'b1;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  assign ready  = ready_r;
  assign busy   = busy_r;
  assign serial = serial_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1 at 217 clks/bit, a 5-bit instance, a fast
// 2-stop-bit instance for many-word loopback decoding. Honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int CPB  = 217;
  localparam int FCPB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data0 = 8'h00, data5 = 8'h00, dataf = 8'h00;
  logic valid0 = 1'b0, valid5 = 1'b0, validf = 1'b0;
  logic ready0, ready5, readyf, busy0, busy5, busyf, serial0, serial5, serialf;

  int   sel = 0;
  logic rdy_m, ser_m, bsy_m;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   ser_a [0:5999];
  bit   rdy_a [0:5999];
  bit   bsy_a [0:5999];
  bit   exp_a [0:5999];

  always #5 clk = ~clk;

  uart_tx u_tx8 (.clk(clk), .rst_n(rst_n), .data(data0), .valid(valid0),
                 .ready(ready0), .busy(busy0), .serial(serial0));
  uart_tx #(.DATA_BITS(5)) u_tx5 (.clk(clk), .rst_n(rst_n), .data(data5), .valid(valid5),
                 .ready(ready5), .busy(busy5), .serial(serial5));
  uart_tx #(.CLK_FREQ(32), .BAUD_RATE(4), .STOP_BITS(2)) u_txf (.clk(clk), .rst_n(rst_n),
                 .data(dataf), .valid(validf), .ready(readyf), .busy(busyf), .serial(serialf));

  // Route the instance under test to the common capture signals.
  always_comb begin
    case (sel)
      1:       begin rdy_m = ready5; ser_m = serial5; bsy_m = busy5; end
      2:       begin rdy_m = readyf; ser_m = serialf; bsy_m = busyf; end
      default: begin rdy_m = ready0; ser_m = serial0; bsy_m = busy0; end
    endcase
  end

  task automatic set_data(input int s, input logic [7:0] d);
    case (s)
      1:       data5 = d;
      2:       dataf = d;
      default: data0 = d;
    endcase
  endtask

  task automatic set_valid(input int s, input logic v);
    case (s)
      1:       valid5 = v;
      2:       validf = v;
      default: valid0 = v;
    endcase
  endtask

  // Present a word and return just after the posedge that accepts it.
  task automatic handshake(input int s, input logic [7:0] d);
    bit ok;
    sel = s;
    @(negedge clk);
    set_data(s, d);
    set_valid(s, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (rdy_m === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL handshake: ready=%b, required 1 within 6000 clks", rdy_m);
    end
    @(posedge clk);
  endtask

  // Sample n cycles at negedges; cycle 0 is the first cycle after the handshake.
  task automatic capture(input int n, input int drop_at, input int chg_at, input logic [7:0] nd);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ser_a[k] = ser_m;
      rdy_a[k] = rdy_m;
      bsy_a[k] = bsy_m;
      if (k == chg_at) set_data(sel, nd);
      if (k == drop_at) set_valid(sel, 1'b0);
    end
  endtask

  // Reference line waveform for one frame, written into exp_a from offset off.
  task automatic build_frame(input logic [7:0] d, input int nb, input int sb, input int cpb,
                             input int off, output int len);
    int pos;
    bit p;
    pos = off;
    p = 1'b0;
    for (int c = 0; c < cpb; c++) begin exp_a[pos] = 1'b0; pos++; end
    for (int i = 0; i < nb; i++) begin
      p = p ^ d[i];
      for (int c = 0; c < cpb; c++) begin exp_a[pos] = d[i]; pos++; end
    end
    if (PAR == 1) begin
      for (int c = 0; c < cpb; c++) begin exp_a[pos] = p; pos++; end
    end
    for (int c = 0; c < sb * cpb; c++) begin exp_a[pos] = 1'b1; pos++; end
    len = pos - off;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (serial0 !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b, required 1", serial0); end
    n_checks++;
    if (ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", ready0); end
    n_checks++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy0); end
    n_checks++;
    if ({serial5, ready5, busy5, serialf, readyf, busyf} !== 6'b110110) begin
      n_fail++;
      $display("FAIL reset_others: got %b, required 110110", {serial5, ready5, busy5, serialf, readyf, busyf});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_8n1();
    int len, rl, at;
    bit bad;
    handshake(0, 8'hA5);
    capture(2175, 0, -1, 8'h00);
    build_frame(8'hA5, 8, 1, CPB, 0, len);
    for (int k = len; k < 2175; k++) exp_a[k] = 1'b1;
    for (int s = 0; s <= len / CPB; s++) begin
      bad = 1'b0; at = 0;
      for (int c = 0; c < CPB && s * CPB + c < 2175; c++) begin
        if (!bad && ser_a[s * CPB + c] !== exp_a[s * CPB + c]) begin bad = 1'b1; at = s * CPB + c; end
      end
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL a5_slot%0d: serial=%b at cycle %0d, required %b", s, ser_a[at], at, exp_a[at]);
      end
    end
    rl = 0;
    while (rl < 2175 && rdy_a[rl] == 1'b0) rl++;
    n_checks++;
    if (rl !== len) begin n_fail++; $display("FAIL a5_ready_low: %0d clks, required %0d", rl, len); end
    bad = 1'b0;
    for (int k = 0; k < 2175; k++) if (bsy_a[k] !== !rdy_a[k]) bad = 1'b1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL a5_busy: busy is not the inverse of ready, required inverse"); end
  endtask

  task automatic test_5bit();
    logic [7:0] words [2];
    int len, rl, at;
    bit bad;
    words[0] = 8'hFF;
    words[1] = 8'hE0;
    for (int w = 0; w < 2; w++) begin
      handshake(1, words[w]);
      capture(1525, 0, -1, 8'h00);
      build_frame(words[w], 5, 1, CPB, 0, len);
      for (int k = len; k < 1525; k++) exp_a[k] = 1'b1;
      bad = 1'b0; at = 0;
      for (int k = 0; k < 1525; k++) begin
        if (!bad && ser_a[k] !== exp_a[k]) begin bad = 1'b1; at = k; end
      end
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL bits5_%h_line: serial=%b at cycle %0d, required %b", words[w], ser_a[at], at, exp_a[at]);
      end
      rl = 0;
      while (rl < 1525 && rdy_a[rl] == 1'b0) rl++;
      n_checks++;
      if (rl !== (7 + PAR) * CPB) begin
        n_fail++;
        $display("FAIL bits5_%h_len: %0d clks, required %0d", words[w], rl, (7 + PAR) * CPB);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] words [2];
    int len, rl, at;
    bit bad;
    words[0] = 8'h07;
    words[1] = 8'h03;
    for (int w = 0; w < 2; w++) begin
      handshake(0, words[w]);
      capture(2392, 0, -1, 8'h00);
      build_frame(words[w], 8, 1, CPB, 0, len);
      for (int k = len; k < 2392; k++) exp_a[k] = 1'b1;
      bad = 1'b0; at = 0;
      for (int k = 0; k < 2392; k++) begin
        if (!bad && ser_a[k] !== exp_a[k]) begin bad = 1'b1; at = k; end
      end
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL parity_%h_line: serial=%b at cycle %0d, required %b", words[w], ser_a[at], at, exp_a[at]);
      end
      rl = 0;
      while (rl < 2392 && rdy_a[rl] == 1'b0) rl++;
      n_checks++;
      if (rl !== (10 + PAR) * CPB) begin
        n_fail++;
        $display("FAIL parity_%h_len: %0d clks, required %0d", words[w], rl, (10 + PAR) * CPB);
      end
    end
  endtask

  task automatic test_back_to_back();
    int len1, len2, tot, at;
    bit bad;
    handshake(0, 8'h11);
    build_frame(8'h11, 8, 1, CPB, 0, len1);
    exp_a[len1] = 1'b1;
    build_frame(8'h22, 8, 1, CPB, len1 + 1, len2);
    tot = len1 + 1 + len2;
    for (int k = tot; k < tot + 3; k++) exp_a[k] = 1'b1;
    capture(tot + 3, len1 + 1, 0, 8'h22);
    bad = 1'b0; at = 0;
    for (int k = 0; k < tot + 3; k++) begin
      if (!bad && ser_a[k] !== exp_a[k]) begin bad = 1'b1; at = k; end
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL b2b_line: serial=%b at cycle %0d, required %b", ser_a[at], at, exp_a[at]);
    end
    n_checks++;
    if ({rdy_a[len1 - 1], rdy_a[len1], rdy_a[len1 + 1]} !== 3'b010) begin
      n_fail++;
      $display("FAIL b2b_ready_gap: got %b, required 010", {rdy_a[len1 - 1], rdy_a[len1], rdy_a[len1 + 1]});
    end
  endtask

  task automatic test_reset_mid();
    int len, at;
    bit bad;
    handshake(0, 8'h3C);
    capture(900, 0, -1, 8'h00);
    n_checks++;
    if ({ser_a[899], rdy_a[899]} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_bit3: serial,ready=%b%b, required 10", ser_a[899], rdy_a[899]);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({serial0, ready0, busy0} !== 3'b110) begin
      n_fail++;
      $display("FAIL midrst_abort: serial,ready,busy=%b, required 110", {serial0, ready0, busy0});
    end
    rst_n = 1'b1;
    handshake(0, 8'h5A);
    capture(2175, 0, -1, 8'h00);
    build_frame(8'h5A, 8, 1, CPB, 0, len);
    for (int k = len; k < 2175; k++) exp_a[k] = 1'b1;
    bad = 1'b0; at = 0;
    for (int k = 0; k < 2175; k++) begin
      if (!bad && (ser_a[k] !== exp_a[k] || rdy_a[k] !== (k >= len))) begin bad = 1'b1; at = k; end
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL midrst_resend: serial=%b ready=%b at cycle %0d, required serial %b", ser_a[at], rdy_a[at], at, exp_a[at]);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] w;
    int len, flen, rl, bad_words;
    bit bad;
    flen = (1 + 8 + PAR + 2) * FCPB;
    bad_words = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 0) w = 8'h00;
      else if (i == 1) w = 8'hFF;
      else w = 8'($urandom_range(0, 255));
      handshake(2, w);
      capture(flen + 1, 0, -1, 8'h00);
      build_frame(w, 8, 2, FCPB, 0, len);
      exp_a[len] = 1'b1;
      bad = 1'b0;
      for (int k = 0; k <= len; k++) if (ser_a[k] !== exp_a[k]) bad = 1'b1;
      rl = 0;
      while (rl <= flen && rdy_a[rl] == 1'b0) rl++;
      n_checks++;
      if (bad || rl != flen) begin
        n_fail++;
        bad_words++;
        if (bad_words <= 5) $display("FAIL loop_%0d: word %h decoded wrong or %0d clks, required %0d", i, w, rl, flen);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_5bit();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
